// File: rtl/countdown_timer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// countdown_timer_if : control inputs and display/status outputs of the timer
// Revision 1.0
// ----------------------------------------------------------------------------
interface countdown_timer_if;
   logic       load;
   logic       start;
   logic [6:0] value;
   logic [0:6] HEX1;
   logic [0:6] HEX0;
   logic       busy;
   logic       done;

   modport master (
      output load, start, value,
      input  HEX1, HEX0, busy, done
   );

   modport slave (
      input  load, start, value,
      output HEX1, HEX0, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// countdown_timer : two-digit BCD countdown with start/pause, 7-segment output
// Revision 1.0
// ----------------------------------------------------------------------------
module countdown_timer #(
   parameter int TICK_DIV = 50000000
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   countdown_timer_if.slave  bus
);

   localparam int                TICK_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [3:0]        tens_q, tens_d;
   logic [3:0]        units_q, units_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic              start_q, start_d;

   logic              start_edge;
   logic [6:0]        clamped;

   function automatic logic [0:6] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b0000001;
         4'd1:    seg7 = 7'b1001111;
         4'd2:    seg7 = 7'b0010010;
         4'd3:    seg7 = 7'b0000110;
         4'd4:    seg7 = 7'b1001100;
         4'd5:    seg7 = 7'b0100100;
         4'd6:    seg7 = 7'b0100000;
         4'd7:    seg7 = 7'b0001111;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0000100;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   always_comb begin
      start_edge = bus.start & ~start_q;
      clamped    = (bus.value > 7'd99) ? 7'd99 : bus.value;

      state_d = state_q;
      tens_d  = tens_q;
      units_d = units_q;
      tick_d  = tick_q;
      start_d = bus.start;

      if (bus.load) begin
         state_d = ST_IDLE;
         tens_d  = 4'(clamped / 7'd10);
         units_d = 4'(clamped % 7'd10);
         tick_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_edge && (tens_q != 4'd0 || units_q != 4'd0)) begin
                  state_d = ST_RUN;
                  tick_d  = '0;
               end
            end
            ST_RUN: begin
               // A pause request freezes the tick counter in this very cycle.
               if (start_edge) begin
                  state_d = ST_PAUSE;
               end else if (tick_q == TICK_LAST) begin
                  tick_d = '0;
                  if (units_q == 4'd0) begin
                     units_d = 4'd9;
                     tens_d  = tens_q - 4'd1;
                  end else begin
                     units_d = units_q - 4'd1;
                  end
                  if (tens_q == 4'd0 && units_q == 4'd1) begin
                     state_d = ST_DONE;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            ST_PAUSE: begin
               if (start_edge) begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= ST_IDLE;
         tens_q  <= 4'd0;
         units_q <= 4'd0;
         tick_q  <= '0;
         start_q <= 1'b1;
      end else begin
         state_q <= state_d;
         tens_q  <= tens_d;
         units_q <= units_d;
         tick_q  <= tick_d;
         start_q <= start_d;
      end
   end

   assign bus.HEX1 = seg7(tens_q);
   assign bus.HEX0 = seg7(units_q);
   assign bus.busy = (state_q == ST_RUN);
   assign bus.done = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_countdown_timer : directed scenarios for countdown_timer with TICK_DIV=4
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_countdown_timer;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   countdown_timer_if bus ();

   countdown_timer #(.TICK_DIV(4)) dut (
      .CLOCK_50 (clk),
      .reset    (rst),
      .bus      (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [13:0] disp(input int t, input int u);
      logic [0:6] tbl [10];
      tbl[0] = 7'b0000001; tbl[1] = 7'b1001111; tbl[2] = 7'b0010010;
      tbl[3] = 7'b0000110; tbl[4] = 7'b1001100; tbl[5] = 7'b0100100;
      tbl[6] = 7'b0100000; tbl[7] = 7'b0001111; tbl[8] = 7'b0000000;
      tbl[9] = 7'b0000100;
      disp = {tbl[t], tbl[u]};
   endfunction

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic load_value(input logic [6:0] v);
      bus.value = v;
      bus.load  = 1'b1;
      step();
      bus.load  = 1'b0;
   endtask

   task automatic start_pulse();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      bus.load = 1'b0; bus.start = 1'b0; bus.value = 7'd0;
      do_reset();
      n_tests++;
      if ({bus.HEX1, bus.HEX0} !== disp(0, 0)) begin
         n_fail++; $display("FAIL reset_hex got %b expected %b", {bus.HEX1, bus.HEX0}, disp(0, 0));
      end
      n_tests++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags got busy=%b done=%b expected 0 0", bus.busy, bus.done);
      end
   endtask

   task automatic test_full_countdown();
      step();
      load_value(7'd3);
      n_tests++;
      if ({bus.HEX1, bus.HEX0} !== disp(0, 3) || bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL full_load got %b busy=%b expected %b busy=0", {bus.HEX1, bus.HEX0}, bus.busy, disp(0, 3));
      end
      start_pulse();
      n_tests++;
      if (bus.busy !== 1'b1) begin
         n_fail++; $display("FAIL full_busy got %b expected 1", bus.busy);
      end
      step(3);
      n_tests++;
      if ({bus.HEX1, bus.HEX0} !== disp(0, 3)) begin
         n_fail++; $display("FAIL full_pre_tick got %b expected %b", {bus.HEX1, bus.HEX0}, disp(0, 3));
      end
      step();
      n_tests++;
      if ({bus.HEX1, bus.HEX0} !== disp(0, 2)) begin
         n_fail++; $display("FAIL full_02 got %b expected %b", {bus.HEX1, bus.HEX0}, disp(0, 2));
      end
      step(4);
      n_tests++;
      if ({bus.HEX1, bus.HEX0} !== disp(0, 1) || bus.busy !== 1'b1) begin
         n_fail++; $display("FAIL full_01 got %b busy=%b expected %b busy=1", {bus.HEX1, bus.HEX0}, bus.busy, disp(0, 1));
      end
      step(4);
      n_tests++;
      if ({bus.HEX1, bus.HEX0} !== disp(0, 0) || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL full_done got %b busy=%b done=%b expected %b busy=0 done=1",
                           {bus.HEX1, bus.HEX0}, bus.busy, bus.done, disp(0, 0));
      end
   endtask

   task automatic test_clamp_borrow();
      load_value(7'd120);
      n_tests++;
      if ({bus.HEX1, bus.HEX0} !== disp(9, 9)) begin
         n_fail++; $display("FAIL clamp got %b expected %b", {bus.HEX1, bus.HEX0}, disp(9, 9));
      end
      load_value(7'd10);
      n_tests++;
      if ({bus.HEX1, bus.HEX0} !== disp(1, 0) || bus.done !== 1'b0) begin
         n_fail++; $display("FAIL load10 got %b done=%b expected %b done=0", {bus.HEX1, bus.HEX0}, bus.done, disp(1, 0));
      end
      start_pulse();
      step(4);
      n_tests++;
      if (bus.HEX1 !== 7'b0000001 || bus.HEX0 !== 7'b0000100) begin
         n_fail++; $display("FAIL borrow got %b %b expected 0000001 0000100", bus.HEX1, bus.HEX0);
      end
   endtask

   task automatic test_pause_resume();
      load_value(7'd50);
      start_pulse();
      step(2);
      start_pulse();
      n_tests++;
      if (bus.busy !== 1'b0 || {bus.HEX1, bus.HEX0} !== disp(5, 0)) begin
         n_fail++; $display("FAIL pause_enter got busy=%b %b expected busy=0 %b", bus.busy, {bus.HEX1, bus.HEX0}, disp(5, 0));
      end
      step(10);
      n_tests++;
      if (bus.busy !== 1'b0 || {bus.HEX1, bus.HEX0} !== disp(5, 0)) begin
         n_fail++; $display("FAIL pause_hold got busy=%b %b expected busy=0 %b", bus.busy, {bus.HEX1, bus.HEX0}, disp(5, 0));
      end
      start_pulse();
      n_tests++;
      if (bus.busy !== 1'b1) begin
         n_fail++; $display("FAIL resume_busy got %b expected 1", bus.busy);
      end
      step();
      n_tests++;
      if ({bus.HEX1, bus.HEX0} !== disp(5, 0)) begin
         n_fail++; $display("FAIL resume_pre_tick got %b expected %b", {bus.HEX1, bus.HEX0}, disp(5, 0));
      end
      step();
      n_tests++;
      if ({bus.HEX1, bus.HEX0} !== disp(4, 9)) begin
         n_fail++; $display("FAIL resume_tick got %b expected %b", {bus.HEX1, bus.HEX0}, disp(4, 9));
      end
   endtask

   task automatic test_priority_edges();
      load_value(7'd5);
      start_pulse();
      step();
      bus.value = 7'd8; bus.load = 1'b1; bus.start = 1'b1;
      step();
      bus.load = 1'b0; bus.start = 1'b0;
      step(3);
      n_tests++;
      if (bus.busy !== 1'b0 || {bus.HEX1, bus.HEX0} !== disp(0, 8)) begin
         n_fail++; $display("FAIL load_priority got busy=%b %b expected busy=0 %b", bus.busy, {bus.HEX1, bus.HEX0}, disp(0, 8));
      end
      load_value(7'd0);
      step();
      start_pulse();
      n_tests++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_fail++; $display("FAIL zero_start got busy=%b done=%b expected 0 0", bus.busy, bus.done);
      end
      load_value(7'd1);
      step();
      start_pulse();
      step(4);
      n_tests++;
      if (bus.done !== 1'b1) begin
         n_fail++; $display("FAIL done_reach got %b expected 1", bus.done);
      end
      step();
      start_pulse();
      step(5);
      n_tests++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || {bus.HEX1, bus.HEX0} !== disp(0, 0)) begin
         n_fail++; $display("FAIL done_start got busy=%b done=%b %b expected busy=0 done=1 %b",
                           bus.busy, bus.done, {bus.HEX1, bus.HEX0}, disp(0, 0));
      end
      load_value(7'd7);
      n_tests++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || {bus.HEX1, bus.HEX0} !== disp(0, 7)) begin
         n_fail++; $display("FAIL done_load got busy=%b done=%b %b expected busy=0 done=0 %b",
                           bus.busy, bus.done, {bus.HEX1, bus.HEX0}, disp(0, 7));
      end
   endtask

   task automatic test_reset_mid_run();
      step();
      load_value(7'd60);
      start_pulse();
      step(12);
      n_tests++;
      if (bus.busy !== 1'b1 || {bus.HEX1, bus.HEX0} !== disp(5, 7)) begin
         n_fail++; $display("FAIL mid_run got busy=%b %b expected busy=1 %b", bus.busy, {bus.HEX1, bus.HEX0}, disp(5, 7));
      end
      rst = 1'b1; bus.load = 1'b1; bus.start = 1'b1; bus.value = 7'd42;
      step();
      rst = 1'b0; bus.load = 1'b0;
      n_tests++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || {bus.HEX1, bus.HEX0} !== disp(0, 0)) begin
         n_fail++; $display("FAIL reset_mid got busy=%b done=%b %b expected busy=0 done=0 %b",
                           bus.busy, bus.done, {bus.HEX1, bus.HEX0}, disp(0, 0));
      end
      step(3);
      bus.start = 1'b0;
      n_tests++;
      if (bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL start_held got busy=%b expected 0", bus.busy);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b0;
      test_reset();
      test_full_countdown();
      test_clamp_borrow();
      test_pause_resume();
      test_priority_edges();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter TICK_DIV, default 50000000, SHALL be the number of CLOCK_50 cycles per countdown step (minimum 2).
REQ-002 CLOCK_50  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 load  input  1  SHALL be a level input; while high, value is loaded.
REQ-005 start  input  1  SHALL be a level input; each 0->1 transition is one start/pause command.
REQ-006 value  input  7  SHALL be the unsigned binary preset, 0-127.
REQ-007 HEX1  output  [0:6]  SHALL drive the tens digit on a 7-segment display, bit 0 = segment a ... bit 6 = segment g, active-low.
REQ-008 HEX0  output  [0:6]  SHALL drive the units digit, same encoding as HEX1.
REQ-009 busy  output  1  SHALL be high exactly while state is RUN.
REQ-010 done  output  1  SHALL be high exactly while state is DONE.

Function
REQ-011 Count SHALL be held as two BCD digits (tens, units), each 0-9; the range is 00-99.
REQ-012 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE, DONE.
REQ-013 Start-edge detection SHALL register start; an edge is start=1 with the previous sample 0.
REQ-014 load=1 SHALL, in any state, set count to min(value, 99) in BCD, enter IDLE, and clear the tick counter on the next edge.
REQ-015 load SHALL take priority over a start edge in the same cycle.
REQ-016 A start edge in IDLE SHALL enter RUN if count != 00; otherwise it SHALL be ignored.
REQ-017 A start edge in RUN SHALL enter PAUSE; a start edge in PAUSE SHALL enter RUN; a start edge in DONE SHALL be ignored.
REQ-018 The tick counter SHALL be cleared on entry to RUN from IDLE.
REQ-019 The tick counter SHALL increment each cycle in RUN, hold in PAUSE, and wrap to 0 after reaching TICK_DIV-1.
REQ-020 A tick SHALL occur in the RUN cycle where the tick counter equals TICK_DIV-1.
REQ-021 On a tick, count SHALL decrement by 1: units 0 SHALL become 9 with a tens borrow; otherwise units decrement.
REQ-022 If a tick decrements count to 00, the same edge SHALL enter DONE.
REQ-023 DONE SHALL be left only via load or reset.
REQ-024 Count SHALL never wrap below 00.
REQ-025 HEX0 and HEX1 SHALL be combinational decodes of the units and tens digits.
REQ-026 Active-low segment patterns, abcdefg order: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-027 busy and done SHALL be registered state decodes with no combinational path from inputs.

Reset
REQ-028 reset=1 at a rising edge SHALL, on that edge, set: state IDLE, count 00, tick counter 0, start-edge register 1.
REQ-029 reset SHALL override load and start, from any state including mid-RUN.
REQ-030 After reset: HEX1=HEX0=0000001, busy=0, done=0.
REQ-031 A start held high through reset release SHALL NOT generate a start edge.

Verification (TICK_DIV=4)
REQ-032 Reset: assert reset 1 cycle -> HEX1=HEX0=0000001, busy=0, done=0.
REQ-033 Full countdown: load value=3, then a start edge -> busy=1 the next cycle; count 02, 01, 00 at 4, 8 and 12 cycles after RUN entry; done=1 and busy=0 with count 00.
REQ-034 Clamp and borrow: load value=120 -> count 99. Load value=10, then start -> after one tick, count 09 (HEX1=0000001, HEX0=0000100).
REQ-035 Pause/resume: start edge 2 cycles after RUN entry -> PAUSE, count and tick counter frozen for 10 cycles. Second start edge -> first tick occurs 2 cycles later.
REQ-036 Priority and edge cases: load and a start edge in the same cycle -> IDLE with the new value, busy=0. Start edge with count 00 -> stays IDLE. Start edge in DONE -> no change.
REQ-037 Reset mid-operation: reset during RUN at count 57 -> next cycle IDLE, count 00, busy=0, done=0.
